// File: rtl/prog_lut_sweep.sv
// rtl/prog_lut_sweep.sv - programmable N-input LUT with registered evaluation and exhaustive sweep engine
module prog_lut_sweep #(
    parameter int                     N_IN       = 5,
    parameter logic [(1<<N_IN)-1:0]   DEFAULT_TT = 32'hFAF7_DF6B
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   in_vec,
    output logic              f_out,
    input  logic              prog_en,
    input  logic [N_IN-1:0]   prog_addr,
    input  logic              prog_data,
    output logic              prog_err,
    input  logic              sweep_start,
    output logic              sweep_busy,
    output logic              sweep_valid,
    input  logic              sweep_ready,
    output logic [N_IN-1:0]   sweep_idx,
    output logic              sweep_f,
    output logic              sweep_done,
    output logic [N_IN:0]     zero_count,
    output logic              zero_found,
    output logic [N_IN-1:0]   first_zero
);

    localparam logic [N_IN-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [(1<<N_IN)-1:0]    tt;
    logic [N_IN-1:0]         idx;
    logic                    accept;

    // State register; reset aborts any sweep in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and stream/status outputs, all decoded from state, idx and the table
    always_comb begin
        state_nxt   = state;
        sweep_busy  = 1'b0;
        sweep_valid = 1'b0;
        sweep_done  = 1'b0;
        prog_err    = 1'b0;
        accept      = 1'b0;
        sweep_idx   = '0;
        sweep_f     = 1'b0;
        case (state)
            IDLE: begin
                if (sweep_start) begin
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                sweep_busy  = 1'b1;
                sweep_valid = 1'b1;
                sweep_idx   = idx;
                sweep_f     = tt[idx];
                prog_err    = prog_en;
                accept      = sweep_ready;
                if (sweep_ready && (idx == LAST_IDX)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                sweep_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Truth table, live evaluation and sweep bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tt         <= DEFAULT_TT;
            f_out      <= 1'b0;
            idx        <= '0;
            zero_count <= '0;
            zero_found <= 1'b0;
            first_zero <= '0;
        end else begin
            // Reads the pre-write table, so a same-cycle write shows up one cycle later
            f_out <= tt[in_vec];
            if (prog_en && (state != SWEEP)) begin
                tt[prog_addr] <= prog_data;
            end
            if ((state == IDLE) && sweep_start) begin
                idx        <= '0;
                zero_count <= '0;
                zero_found <= 1'b0;
                first_zero <= '0;
            end
            if (accept) begin
                if (!tt[idx]) begin
                    zero_count <= zero_count + 1'b1;
                    if (!zero_found) begin
                        zero_found <= 1'b1;
                        first_zero <= idx;
                    end
                end
                // Last index is held rather than wrapped; DONE follows
                if (idx != LAST_IDX) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/prog_lut_sweep.md
Name: prog_lut_sweep

Overview:
- Parametrised, programmable N-input single-output boolean function unit; next generation of the team's fixed 5-input gate-level/dataflow/behavioural function blocks.
- Truth table held in a 2**N_IN-bit register: reset-loaded with the current fixed function, rewritable one bit per cycle.
- Registered live evaluation path, plus an on-chip exhaustive sweep engine that streams every input combination with a valid/ready handshake and reports the count and position of zero outputs.

Parameters:
- N_IN, 5, number of function inputs (1..8).
- DEFAULT_TT, 32'hFAF7_DF6B, reset truth table, width 2**N_IN; bit i = F for input vector i. The default is the current 5-input function, zero at minterms 2, 4, 7, 13, 19, 24, 26.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_vec  in  N_IN  live function input, MSB = first variable (A).
- f_out  out  1  registered F for in_vec.
- prog_en  in  1  write strobe for one truth-table bit.
- prog_addr  in  N_IN  truth-table bit index to write.
- prog_data  in  1  value to write.
- prog_err  out  1  one-cycle pulse: write rejected because a sweep is active.
- sweep_start  in  1  start an exhaustive sweep.
- sweep_busy  out  1  high while in SWEEP.
- sweep_valid  out  1  stream beat valid.
- sweep_ready  in  1  consumer ready.
- sweep_idx  out  N_IN  input vector of the current beat.
- sweep_f  out  1  table value at sweep_idx.
- sweep_done  out  1  one-cycle pulse after the last beat is accepted.
- zero_count  out  N_IN+1  number of zero entries seen in the last sweep.
- zero_found  out  1  at least one zero was seen in the last sweep.
- first_zero  out  N_IN  lowest index with F=0; meaningful only when zero_found=1.

Behaviour:
- Reset, on a clk edge with rst_n=0, overrides everything, including mid-sweep:
  - table := DEFAULT_TT;
  - state := IDLE;
  - f_out, prog_err, sweep_busy, sweep_valid, sweep_idx, sweep_f, sweep_done, zero_count, zero_found, first_zero all 0.
- Evaluation:
  - f_out <= table[in_vec] every cycle in every state; latency 1 clock.
  - Read-before-write: if prog_en writes the addressed bit in the same cycle, f_out shows the old value; the new value appears on the following cycle.
- Programming:
  - In IDLE or DONE with prog_en=1: table[prog_addr] <= prog_data.
  - In SWEEP: the write is dropped and prog_err=1 for that cycle.
- FSM states: IDLE, SWEEP, DONE.
  - IDLE -> SWEEP on sweep_start=1. On that edge: idx := 0, zero_count := 0, zero_found := 0, first_zero := 0.
  - sweep_start is ignored in SWEEP and DONE.
  - If prog_en and sweep_start coincide in IDLE, the write commits on that same edge and the sweep sees the new value.
- SWEEP handshake:
  - sweep_valid=1, sweep_idx=idx, sweep_f=table[idx]; combinational from state, idx and table.
  - A beat is accepted when sweep_valid && sweep_ready.
  - While sweep_ready=0: idx and all outputs hold.
  - On an accepted beat with sweep_f=0: zero_count += 1. If zero_found was 0: first_zero := idx and zero_found := 1.
  - On an accepted beat with idx < 2**N_IN-1: idx += 1.
  - On an accepted beat with idx = 2**N_IN-1: go to DONE. idx does not wrap.
- DONE, exactly 1 cycle: sweep_done=1, sweep_valid=0, then go to IDLE.
- Result hold: zero_count, zero_found and first_zero hold their values until the next sweep starts or reset.
- Width rule: zero_count is N_IN+1 bits, so an all-zero table reports 2**N_IN without overflow.
- Beat count: a sweep delivers exactly 2**N_IN beats in ascending order. Minimum duration with sweep_ready tied high: 2**N_IN cycles in SWEEP + 1 cycle in DONE.

Test Plan:
- After reset, in_vec=5'b01101 -> f_out=0 one cycle later; in_vec=5'b11111 -> f_out=1; all 32 vectors match DEFAULT_TT.
- Reset, pulse sweep_start, sweep_ready=1 -> 32 beats with idx 0..31, sweep_done pulse on cycle 33; zero_count=7, zero_found=1, first_zero=2.
- Program addr 31 to 0 and addr 2 to 1, then sweep -> zero_count=7, first_zero=4; in_vec=31 -> f_out=0.
- sweep_ready toggled with a pseudo-random pattern -> idx advances only on accepted beats; still exactly 32 beats, zero_count=7. Also during SWEEP: prog_en=1 -> prog_err pulse, table unchanged; second sweep_start -> ignored.
- rst_n=0 for one edge at idx=10, after a prior write of addr 0 to 0 -> state IDLE, sweep_valid=0, table back to DEFAULT_TT (in_vec=0 -> f_out=1), zero_count=0.
- N_IN=3 with DEFAULT_TT=8'h00, sweep -> zero_count=8 (4'b1000), first_zero=0, 8 beats.
